// File: rtl/food_spawn_ctrl.sv
// Food spawn sequencer: samples the LFSR over the shared bus, checks each candidate cell
// against snake occupancy, retries, then falls back to a linear scan. Option: FOOD_AVOID_LAST_EN.

module food_spawn_ctrl #(
   parameter int unsigned MAX_TRIES = 16,
   parameter int unsigned GRID_BITS = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req,
   output logic                 busy,
   output logic                 done,
   output logic                 fail,
   output logic [GRID_BITS-1:0] food_x,
   output logic [GRID_BITS-1:0] food_y,
   output logic                 bus_req,
   input  logic                 bus_gnt,
   output logic                 c_lfsr,
   input  logic [7:0]           bus_in,
   output logic                 occ_req,
   output logic [GRID_BITS-1:0] occ_x,
   output logic [GRID_BITS-1:0] occ_y,
   input  logic                 occ_ack,
   input  logic                 occ_hit
);

   localparam int unsigned CELL_BITS = 2 * GRID_BITS;
   localparam logic [7:0]  TRY_LIMIT = 8'(MAX_TRIES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BUS_WAIT,
      S_SAMPLE,
      S_QUERY,
      S_SCAN,
      S_SCAN_Q,
      S_ACCEPT,
      S_FAIL
   } state_t;

   state_t               state, state_n;
   logic [CELL_BITS-1:0] cand, cand_n, cand_inc, sample;
   logic [CELL_BITS-1:0] scan_cnt, scan_n;
   logic [CELL_BITS-1:0] food, food_n;
   logic [7:0]           try_cnt, try_n, try_inc;
   logic                 sample_is_last, inc_is_last;
   logic                 unused_bus_bits;

   // Cells are packed as {x,y}, so incrementing cand advances y first and carries into x.
   assign sample   = {bus_in[4 +: GRID_BITS], bus_in[0 +: GRID_BITS]};
   assign cand_inc = cand + CELL_BITS'(1);
   assign try_inc  = try_cnt + 8'd1;
   assign unused_bus_bits = bus_in[7] ^ bus_in[3];

   assign food_x = food[CELL_BITS-1:GRID_BITS];
   assign food_y = food[GRID_BITS-1:0];
   assign occ_x  = cand[CELL_BITS-1:GRID_BITS];
   assign occ_y  = cand[GRID_BITS-1:0];

`ifdef FOOD_AVOID_LAST_EN
   assign sample_is_last = (sample == food);
   assign inc_is_last    = (cand_inc == food);
`else
   assign sample_is_last = 1'b0;
   assign inc_is_last    = 1'b0;
`endif

   always_comb begin
      // NOTE: every signal gets a default here so no path through the case infers a latch.
      state_n = state;
      cand_n  = cand;
      try_n   = try_cnt;
      scan_n  = scan_cnt;
      food_n  = food;
      busy    = 1'b0;
      done    = 1'b0;
      fail    = 1'b0;
      bus_req = 1'b0;
      c_lfsr  = 1'b0;
      occ_req = 1'b0;

      case (state)
         S_IDLE: begin
            if (req) begin
               try_n   = '0;
               state_n = S_BUS_WAIT;
            end
         end
         S_BUS_WAIT: begin
            busy    = 1'b1;
            bus_req = 1'b1;
            if (bus_gnt) state_n = S_SAMPLE;
         end
         S_SAMPLE: begin
            busy    = 1'b1;
            bus_req = 1'b1;
            c_lfsr  = 1'b1;
            cand_n  = sample;
            try_n   = try_inc;
            if (!sample_is_last) begin
               state_n = S_QUERY;
            end else if (try_inc >= TRY_LIMIT) begin
               scan_n  = '0;
               state_n = S_SCAN;
            end else begin
               state_n = S_BUS_WAIT;
            end
         end
         S_QUERY: begin
            busy    = 1'b1;
            occ_req = 1'b1;
            if (occ_ack) begin
               if (!occ_hit) begin
                  food_n  = cand;
                  state_n = S_ACCEPT;
               end else if (try_cnt >= TRY_LIMIT) begin
                  scan_n  = '0;
                  state_n = S_SCAN;
               end else begin
                  state_n = S_BUS_WAIT;
               end
            end
         end
         S_SCAN: begin
            busy   = 1'b1;
            cand_n = cand_inc;
            if (!inc_is_last) begin
               state_n = S_SCAN_Q;
            end else begin
               // The previous food cell is skipped but still counts toward the 64 cells.
               scan_n  = scan_cnt + CELL_BITS'(1);
               state_n = (scan_cnt == '1) ? S_FAIL : S_SCAN;
            end
         end
         S_SCAN_Q: begin
            busy    = 1'b1;
            occ_req = 1'b1;
            if (occ_ack) begin
               scan_n = scan_cnt + CELL_BITS'(1);
               if (!occ_hit) begin
                  food_n  = cand;
                  state_n = S_ACCEPT;
               end else if (scan_cnt == '1) begin
                  state_n = S_FAIL;
               end else begin
                  state_n = S_SCAN;
               end
            end
         end
         S_ACCEPT: begin
            done    = 1'b1;
            state_n = S_IDLE;
         end
         S_FAIL: begin
            fail    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         cand     <= '0;
         try_cnt  <= '0;
         scan_cnt <= '0;
         food     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         state    <= state_n;
         cand     <= cand_n;
         try_cnt  <= try_n;
         scan_cnt <= scan_n;
         food     <= food_n;
      end
   end

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Bench for food_spawn_ctrl: plays arbiter, LFSR and occupancy unit, and checks every
// query, pulse and result against a sample-list/occupancy-map model of the spawn rules.

module tb_food_spawn_ctrl;

   localparam int MAX_TRIES = 2;
`ifdef FOOD_AVOID_LAST_EN
   localparam bit AVOID = 1'b1;
`else
   localparam bit AVOID = 1'b0;
`endif
   localparam int ALL_OCC_Q = AVOID ? MAX_TRIES + 63 : MAX_TRIES + 64;

   logic       clk, reset, req, busy, done, fail;
   logic [2:0] food_x, food_y, occ_x, occ_y;
   logic       bus_req, bus_gnt, c_lfsr, occ_req, occ_ack, occ_hit;
   logic [7:0] bus_in;

   int total = 0, bad = 0;
   int lfsr_pulses = 0, query_cnt = 0, done_seen = 0, fail_seen = 0;

   logic [63:0] occ_map = '0;
   logic [7:0]  lfsr_q[$];
   logic [5:0]  exp_q[$];
   bit          exp_accept = 1'b0;
   logic [5:0]  exp_food = '0, model_food = '0;
   int          exp_pulses = 0;
   bit          inject_ack = 1'b0;

   food_spawn_ctrl #(.MAX_TRIES(MAX_TRIES), .GRID_BITS(3)) dut (
      .clk(clk), .reset(reset), .req(req), .busy(busy), .done(done), .fail(fail),
      .food_x(food_x), .food_y(food_y), .bus_req(bus_req), .bus_gnt(bus_gnt),
      .c_lfsr(c_lfsr), .bus_in(bus_in), .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y),
      .occ_ack(occ_ack), .occ_hit(occ_hit)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected query sequence and outcome, straight from the spawn rules.
   task automatic model_spawn();
      logic [5:0] c;
      bit found;
      c = '0;
      found = 1'b0;
      exp_q.delete();
      exp_pulses = 0;
      exp_accept = 1'b0;
      exp_food   = model_food;
      for (int i = 0; i < MAX_TRIES && i < lfsr_q.size(); i++) begin
         c = {lfsr_q[i][6:4], lfsr_q[i][2:0]};
         exp_pulses++;
         if (AVOID && c == model_food) continue;
         exp_q.push_back(c);
         if (!occ_map[c]) begin
            exp_accept = 1'b1;
            exp_food   = c;
            found      = 1'b1;
            break;
         end
      end
      if (!found) begin
         for (int k = 0; k < 64; k++) begin
            c = c + 6'd1;
            if (AVOID && c == model_food) continue;
            exp_q.push_back(c);
            if (!occ_map[c]) begin
               exp_accept = 1'b1;
               exp_food   = c;
               break;
            end
         end
      end
   endtask

   // LFSR/bus: present the next sample while c_lfsr is high, junk otherwise.
   initial begin
      bus_in = 8'hCC;
      forever begin
         @(negedge clk);
         if (c_lfsr && lfsr_q.size() > 0) bus_in = lfsr_q.pop_front();
         else bus_in = 8'hCC;
      end
   end

   // Occupancy unit: acknowledges in the cycle after occ_req is first seen.
   initial begin
      bit seen;
      seen = 1'b0;
      occ_ack = 1'b0;
      occ_hit = 1'b0;
      forever begin
         @(negedge clk);
         if (!occ_req) begin
            occ_ack = inject_ack;
            occ_hit = 1'b0;
            seen    = 1'b0;
         end else if (occ_ack) begin
            occ_ack = 1'b0;
         end else if (seen) begin
            occ_ack = 1'b1;
            occ_hit = occ_map[{occ_x, occ_y}];
            seen    = 1'b0;
         end else begin
            seen = 1'b1;
         end
      end
   end

   initial begin
      logic [5:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (occ_req && occ_ack) begin
            query_cnt++;
            check("query_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("occ_cell", {occ_x, occ_y}, e);
            end
         end
         if (c_lfsr) begin
            lfsr_pulses++;
            check("bus_req_with_lfsr", bus_req, 1);
         end
         if (occ_req) check("bus_free_in_query", bus_req, 0);
         if (bus_req || occ_req) check("busy_while_active", busy, 1);
         if (done) begin
            done_seen++;
            check("done_not_busy", busy, 0);
            check("done_expected", exp_accept, 1);
            check("done_food", {food_x, food_y}, exp_food);
         end
         if (fail) begin
            fail_seen++;
            check("fail_not_busy", busy, 0);
            check("fail_expected", exp_accept, 0);
            check("fail_food_kept", {food_x, food_y}, model_food);
         end
      end
   end

   task automatic run_spawn(input bit req_on_done, output int lat);
      int d0, f0;
      model_spawn();
      lfsr_pulses = 0;
      d0 = done_seen;
      f0 = fail_seen;
      @(negedge clk); #1 req = 1'b1;
      @(negedge clk); #1 req = 1'b0;
      #1;
      lat = -1;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         if (done || fail) begin
            lat = cyc;
            break;
         end
         @(negedge clk); #2;
      end
      check("finished_in_budget", int'(lat >= 0), 1);
      if (req_on_done) begin
         #1 req = 1'b1;
         @(negedge clk); #1 req = 1'b0;
         #1;
      end else begin
         @(negedge clk); #2;
      end
      check("idle_after", busy, 0);
      @(negedge clk); #2;
      check("still_idle", busy, 0);
      check("lfsr_pulses", lfsr_pulses, exp_pulses);
      check("queries_left", exp_q.size(), 0);
      check("done_count", done_seen - d0, exp_accept ? 1 : 0);
      check("fail_count", fail_seen - f0, exp_accept ? 0 : 1);
      if (exp_accept) model_food = exp_food;
      lfsr_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int lat, d0, q0;
      reset   = 1'b0;
      req     = 1'b0;
      bus_gnt = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      check("rst_ctrl_outs", {busy, done, fail, bus_req, c_lfsr, occ_req}, 0);
      check("rst_food", {food_x, food_y}, 0);
      check("rst_occ_xy", {occ_x, occ_y}, 0);
      @(negedge clk); #1 reset = 1'b1;

      // Single sample, miss: minimum latency, bits 7/3 ignored; req at done is dropped.
      occ_map = '0;
      lfsr_q.push_back(8'hB5);
      run_spawn(1'b1, lat);
      check("t1_latency", lat, 4);
      check("t1_food", {food_x, food_y}, 6'o35);
      check("t1_one_pulse", lfsr_pulses, 1);

      // Re-sampling the current food cell.
      occ_map = '0;
      lfsr_q.push_back(8'h35);
      lfsr_q.push_back(8'h12);
      run_spawn(1'b0, lat);
`ifdef FOOD_AVOID_LAST_EN
      check("avoid_food", {food_x, food_y}, 6'o12);
      check("avoid_pulses", lfsr_pulses, 2);
`else
      check("avoid_food", {food_x, food_y}, 6'o35);
      check("avoid_pulses", lfsr_pulses, 1);
`endif

      // Reset while querying aborts immediately.
      occ_map = '0;
      lfsr_q.push_back(8'hB5);
      d0 = done_seen;
      @(negedge clk); #1 req = 1'b1;
      @(negedge clk); #1 req = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk); #2;
         if (occ_req) break;
      end
      check("rst_reached_query", occ_req, 1);
      #1 reset = 1'b0;
      #1;
      check("rst_mid_occ_req", occ_req, 0);
      check("rst_mid_bus_req", bus_req, 0);
      check("rst_mid_busy", busy, 0);
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      model_food = '0;
      lfsr_q.delete();
      repeat (3) begin
         @(negedge clk); #2;
      end
      check("rst_after_busy", busy, 0);
      check("rst_after_food", {food_x, food_y}, 0);
      check("rst_no_done", done_seen - d0, 0);

      // Hit then miss.
      occ_map = '0;
      occ_map[6'o12] = 1'b1;
      lfsr_q.push_back(8'h12);
      lfsr_q.push_back(8'h77);
      run_spawn(1'b0, lat);
      check("t2_food", {food_x, food_y}, 6'o77);
      check("t2_pulses", lfsr_pulses, 2);

      // Both samples hit: scan wraps (7,7)->(0,0) then (0,1).
      occ_map = '1;
      occ_map[6'o01] = 1'b0;
      lfsr_q.push_back(8'h77);
      lfsr_q.push_back(8'h77);
      run_spawn(1'b0, lat);
      check("t3_food", {food_x, food_y}, 6'o01);

      // Grant withheld, spurious ack and extra req while busy are all ignored.
      occ_map = '0;
      lfsr_q.push_back(8'h6B);
      bus_gnt = 1'b0;
      fork
         run_spawn(1'b0, lat);
         begin
            repeat (3) @(negedge clk);
            #1 inject_ack = 1'b1;
            req = 1'b1;
            #1;
            check("gnt_wait_bus_req", bus_req, 1);
            check("gnt_wait_no_lfsr", c_lfsr, 0);
            @(negedge clk); #1 inject_ack = 1'b0;
            req = 1'b0;
            @(negedge clk); #1;
            check("gnt_still_waiting", bus_req, 1);
            bus_gnt = 1'b1;
         end
      join
      check("gnt_food", {food_x, food_y}, 6'o63);

      // Every cell occupied: fail pulse, food unchanged.
      occ_map = '1;
      lfsr_q.push_back(8'h00);
      lfsr_q.push_back(8'h3F);
      q0 = query_cnt;
      run_spawn(1'b0, lat);
      check("full_queries", query_cnt - q0, ALL_OCC_Q);
      check("full_food_kept", {food_x, food_y}, 6'o63);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
